// File: rtl/video_pkg.sv
// Shared video datapath definitions: pixel mode encodings and the bits-per-pixel decode.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_1BPP = 2'b00,
    MODE_2BPP = 2'b01,
    MODE_4BPP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Reserved encoding falls back to 1bpp so a bad Mode never stalls the line.
  function automatic int unsigned bpp_of(input logic [1:0] mode);
    case (mode)
      MODE_2BPP: return 32'd2;
      MODE_4BPP: return 32'd4;
      default:   return 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/pixel_serialiser_if.sv
// Fetch-word handshake between the video fetch sequencer (master) and the pixel serialiser (slave).
interface pixel_serialiser_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] Data;
    logic              DataValid;
    logic              DataReady;

    modport master (output Data, output DataValid, input DataReady);
    modport slave  (input Data, input DataValid, output DataReady);
endinterface

// File: rtl/pixel_hold_reg.sv
// Holding register for the next fetch word; it can be refilled in the same cycle it hands off.
module pixel_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              LineStart,
    input  logic              i_transfer,
    pixel_serialiser_if.slave bus,
    output logic [DATA_W-1:0] o_word,
    output logic              o_full
);

    logic              r_full;
    logic [DATA_W-1:0] r_word;
    logic              w_accept;

    // Gated by nReset so the fetcher sees a stalled port while the block is held in reset.
    assign bus.DataReady = nReset & ~LineStart & (~r_full | i_transfer);
    assign w_accept      = bus.DataValid & bus.DataReady;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_full <= 1'b0;
            r_word <= '0;
        end else if (LineStart) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_word <= bus.Data;
            r_full <= 1'b1;
        end else if (i_transfer) begin
            r_full <= 1'b0;
        end
    end

    assign o_word = r_word;
    assign o_full = r_full;

endmodule

// File: rtl/pixel_serialiser.sv
// Double-buffered MSB-first pixel shifter at 1/2/4 bpp with underrun flagging.
// Optional pixel doubling is built in when PIXEL_DOUBLE_EN is defined (adds DoubleWidth).
module pixel_serialiser
    import video_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_BPP = 4
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic               PixelEn,
    input  logic [1:0]         Mode,
    input  logic               LineStart,
`ifdef PIXEL_DOUBLE_EN
    input  logic               DoubleWidth,
`endif
    pixel_serialiser_if.slave  fetch,
    output logic [MAX_BPP-1:0] Pixel,
    output logic               PixelValid,
    output logic               Underrun
);

    localparam int RW = $clog2(DATA_W + 1);

    // Modes wider than the build supports degrade to 1bpp.
    function automatic int unsigned eff_bpp(input logic [1:0] m);
        int unsigned b;
        b = bpp_of(m);
        return (b > $unsigned(MAX_BPP)) ? 32'd1 : b;
    endfunction

    logic [DATA_W-1:0] r_shift;
    logic [RW-1:0]     r_remain;
    logic              r_shift_full;
    logic [1:0]        r_active_mode;
    logic              r_armed;
    logic              r_underrun;

    logic              w_step;
    logic              w_transfer;
    logic              w_hold_full;
    logic [DATA_W-1:0] w_hold_word;
    int unsigned       w_act_bpp;
    logic [RW-1:0]     w_load_remain;

`ifdef PIXEL_DOUBLE_EN
    logic r_toggle;

    // Every other strobe advances; the first strobe of each pair only holds the pixel.
    assign w_step = PixelEn & (~DoubleWidth | r_toggle);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)                    r_toggle <= 1'b0;
        else if (LineStart)             r_toggle <= 1'b0;
        else if (w_transfer)            r_toggle <= 1'b0;
        else if (PixelEn & DoubleWidth) r_toggle <= ~r_toggle;
    end
`else
    assign w_step = PixelEn;
`endif

    assign w_transfer    = w_step & (~r_shift_full | (r_remain == RW'(1))) &
                           w_hold_full & ~LineStart;
    assign w_act_bpp     = eff_bpp(r_active_mode);
    assign w_load_remain = RW'(DATA_W / eff_bpp(Mode));

    pixel_hold_reg #(.DATA_W(DATA_W)) u_hold (
        .Clk        (Clk),
        .nReset     (nReset),
        .LineStart  (LineStart),
        .i_transfer (w_transfer),
        .bus        (fetch),
        .o_word     (w_hold_word),
        .o_full     (w_hold_full)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_shift       <= '0;
            r_remain      <= '0;
            r_shift_full  <= 1'b0;
            r_active_mode <= MODE_1BPP;
            r_armed       <= 1'b0;
            r_underrun    <= 1'b0;
        end else if (LineStart) begin
            r_shift       <= '0;
            r_remain      <= '0;
            r_shift_full  <= 1'b0;
            r_armed       <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            // Only a strobe that finds both stages empty after the first word counts as underrun.
            r_underrun <= w_step & ~r_shift_full & ~w_hold_full & r_armed;
            if (w_transfer) begin
                r_shift       <= w_hold_word;
                r_remain      <= w_load_remain;
                r_active_mode <= Mode;
                r_shift_full  <= 1'b1;
                r_armed       <= 1'b1;
            end else if (w_step & r_shift_full) begin
                if (r_remain > RW'(1)) begin
                    r_shift  <= r_shift << w_act_bpp;
                    r_remain <= r_remain - RW'(1);
                end else begin
                    r_shift      <= '0;
                    r_remain     <= '0;
                    r_shift_full <= 1'b0;
                end
            end
        end
    end

    // Right-shifting the word leaves exactly the top bpp bits, already zero-extended.
    assign Pixel      = r_shift_full ? MAX_BPP'(r_shift >> (DATA_W - w_act_bpp)) : '0;
    assign PixelValid = r_shift_full;
    assign Underrun   = r_underrun;

endmodule

// File: tb/tb_pixel_serialiser.sv
// Self-checking bench for pixel_serialiser: directed scenarios plus randomized traffic vs a queue model.
module tb_pixel_serialiser;

    localparam int DATA_W  = 8;
    localparam int MAX_BPP = 4;

    logic               Clk = 1'b0;
    logic               nReset = 1'b0;
    logic               pe = 1'b0;
    logic               ls = 1'b0;
    logic [1:0]         mode = 2'b00;
    logic [MAX_BPP-1:0] Pixel;
    logic               PixelValid;
    logic               Underrun;
    logic [6:0]         act;

    int n_chk = 0;
    int n_fail = 0;

    // model state: held word, remaining pixels of the word on display, armed flag, underrun pulse
    logic [7:0] src_q[$];
    logic [3:0] m_pix[$];
    logic [7:0] m_hold;
    bit         m_hold_v, m_armed, m_under;
    int         xfer_cnt = 0;

    pixel_serialiser_if #(.DATA_W(DATA_W)) fetch ();

    always #5 Clk = ~Clk;

    pixel_serialiser #(.DATA_W(DATA_W), .MAX_BPP(MAX_BPP)) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .PixelEn    (pe),
        .Mode       (mode),
        .LineStart  (ls),
`ifdef PIXEL_DOUBLE_EN
        .DoubleWidth(1'b0),
`endif
        .fetch      (fetch),
        .Pixel      (Pixel),
        .PixelValid (PixelValid),
        .Underrun   (Underrun)
    );

    assign act = {Pixel, PixelValid, Underrun, fetch.DataReady};

    function automatic int bpp(input logic [1:0] m);
        return (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    endfunction

    function automatic bit m_xfer();
        return pe && !ls && m_hold_v && (m_pix.size() <= 1);
    endfunction

    function automatic bit m_ready();
        return nReset && !ls && (!m_hold_v || m_xfer());
    endfunction

    function automatic logic [6:0] exp_vec();
        logic [3:0] p;
        p = (m_pix.size() > 0) ? m_pix[0] : 4'd0;
        return {p, m_pix.size() > 0, m_under, m_ready()};
    endfunction

    task automatic refresh_src();
        fetch.DataValid = src_q.size() > 0;
        fetch.Data      = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
    endtask

    task automatic model_reset();
        m_hold_v = 0; m_armed = 0; m_under = 0;
        m_pix.delete();
        src_q.delete();
    endtask

    // advance one clock edge: update the model from the inputs seen at that edge
    task automatic tick();
        bit acc, xf;
        int b;
        @(posedge Clk);
        acc = fetch.DataValid && m_ready();
        xf  = m_xfer();
        if (ls) begin
            m_hold_v = 0; m_armed = 0; m_under = 0;
            m_pix.delete();
        end else begin
            m_under = pe && (m_pix.size() == 0) && !m_hold_v && m_armed;
            if (xf) begin
                b = bpp(mode);
                m_pix.delete();
                for (int i = 0; i < 8 / b; i++)
                    m_pix.push_back(4'((m_hold >> (8 - b * (i + 1))) & ((1 << b) - 1)));
                m_armed = 1;
                xfer_cnt++;
            end else if (pe && m_pix.size() > 0) begin
                void'(m_pix.pop_front());
            end
            if (acc) begin
                m_hold = fetch.Data; m_hold_v = 1;
            end else if (xf) begin
                m_hold_v = 0;
            end
        end
        if (acc) void'(src_q.pop_front());
        #1;
        refresh_src();
    endtask

    task automatic flush();
        ls = 1; pe = 0;
        src_q.delete();
        refresh_src();
        tick();
        ls = 0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        n_chk++;
        if (act !== 7'b0) begin
            n_fail++; $display("FAIL reset_held: got %b want %b", act, 7'b0);
        end
        @(posedge Clk); #1;
        nReset = 1;
        model_reset();
        refresh_src();
        @(negedge Clk);
        n_chk++;
        if (act !== 7'b0000001) begin
            n_fail++; $display("FAIL reset_release: got %b want %b", act, 7'b0000001);
        end
        tick();
    endtask

    task automatic test_1bpp();
        logic [15:0] got;
        int np, nu;
        flush();
        mode = 2'b00; pe = 1;
        src_q = '{8'hA5, 8'h3C};
        refresh_src();
        got = '0; np = 0; nu = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge Clk);
            n_chk++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL 1bpp cyc %0d: got %b want %b", c, act, exp_vec());
            end
            if (PixelValid) begin got = {got[14:0], Pixel[0]}; np++; end
            if (Underrun) nu++;
            tick();
        end
        n_chk++;
        if (got !== 16'b1010010100111100 || np != 16 || nu != 0) begin
            n_fail++;
            $display("FAIL 1bpp_seq: got %b n=%0d und=%0d want 1010010100111100 n=16 und=0", got, np, nu);
        end
    endtask

    task automatic test_mode_switch();
        logic [23:0] got;
        int np, x0;
        flush();
        mode = 2'b01; pe = 1;
        src_q = '{8'hE4, 8'h7F};
        refresh_src();
        x0 = xfer_cnt; got = '0; np = 0;
        for (int c = 0; c < 12; c++) begin
            if (xfer_cnt - x0 >= 1) mode = 2'b10;
            @(negedge Clk);
            n_chk++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL mode_sw cyc %0d: got %b want %b", c, act, exp_vec());
            end
            if (PixelValid) begin got = {got[19:0], Pixel}; np++; end
            tick();
        end
        n_chk++;
        if (got !== 24'h32107F || np != 6) begin
            n_fail++; $display("FAIL mode_sw_seq: got %h n=%0d want 32107f n=6", got, np);
        end
    endtask

    task automatic test_underrun();
        logic [15:0] got;
        int np, nu;
        flush();
        mode = 2'b01; pe = 1;
        src_q = '{8'hFF};
        refresh_src();
        got = '0; np = 0; nu = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            n_chk++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL underrun cyc %0d: got %b want %b", c, act, exp_vec());
            end
            if (PixelValid) begin got = {got[11:0], Pixel}; np++; end
            if (Underrun) nu++;
            tick();
        end
        n_chk++;
        if (got !== 16'h3333 || np != 4 || nu != 5) begin
            n_fail++; $display("FAIL underrun_cnt: got %h n=%0d und=%0d want 3333 n=4 und=5", got, np, nu);
        end
    endtask

    task automatic test_linestart();
        logic [7:0] w3, got;
        int np, nu, b;
        flush();
        mode = 2'($urandom_range(0, 2)); b = bpp(mode);
        pe = 0;
        src_q = '{8'($urandom)};
        refresh_src();
        @(negedge Clk); tick();
        ls = 1;
        src_q = '{8'($urandom)};
        refresh_src();
        @(negedge Clk);
        n_chk++;
        if (fetch.DataReady !== 1'b0) begin
            n_fail++; $display("FAIL ls_ready: got %b want 0", fetch.DataReady);
        end
        tick();
        ls = 0;
        src_q.delete(); refresh_src();
        @(negedge Clk);
        n_chk++;
        if (PixelValid !== 1'b0 || fetch.DataReady !== 1'b1) begin
            n_fail++; $display("FAIL ls_after: got valid=%b ready=%b want valid=0 ready=1", PixelValid, fetch.DataReady);
        end
        tick();
        pe = 1; nu = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (Underrun) nu++;
            tick();
        end
        n_chk++;
        if (nu != 0) begin
            n_fail++; $display("FAIL ls_no_underrun: got %0d pulses want 0", nu);
        end
        w3 = 8'($urandom);
        src_q = '{w3}; refresh_src();
        got = '0; np = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge Clk);
            n_chk++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL ls_run cyc %0d: got %b want %b", c, act, exp_vec());
            end
            if (PixelValid && np < 8 / b) begin got = (got << b) | 8'(Pixel); np++; end
            tick();
        end
        n_chk++;
        if (got !== w3 || np != 8 / b) begin
            n_fail++; $display("FAIL ls_word: got %h n=%0d want %h", got, np, w3);
        end
    endtask

    task automatic test_throughput();
        logic [7:0] w;
        int b, np, got, c;
        int unsigned base;
        flush();
        mode = 2'($urandom_range(0, 2)); b = bpp(mode);
        base = $urandom;
        for (int i = 0; i < 64; i++) src_q.push_back(8'(base + i));
        refresh_src();
        w = '0; np = 0; got = 0; c = 0;
        while (got < 64 && c < 3000) begin
            pe = (c % 4 == 0);
            @(negedge Clk);
            n_chk++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL thru cyc %0d: got %b want %b", c, act, exp_vec());
            end
            if (pe && PixelValid) begin
                w = (w << b) | 8'(Pixel); np++;
                if (np == 8 / b) begin
                    n_chk++;
                    if (w !== 8'(base + got)) begin
                        n_fail++; $display("FAIL thru_word %0d: got %h want %h", got, w, 8'(base + got));
                    end
                    got++; np = 0; w = '0;
                end
            end
            tick();
            c++;
        end
        n_chk++;
        if (got != 64) begin
            n_fail++; $display("FAIL thru_timeout: got %0d words want 64", got);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] w3, got;
        int np, b;
        flush();
        mode = 2'($urandom_range(0, 2)); b = bpp(mode);
        pe = 1;
        src_q = '{8'($urandom), 8'($urandom)};
        refresh_src();
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            n_chk++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL arst_pre cyc %0d: got %b want %b", c, act, exp_vec());
            end
            tick();
        end
        @(negedge Clk); #2;
        nReset = 0;
        #1;
        n_chk++;
        if (act !== 7'b0) begin
            n_fail++; $display("FAIL arst_immediate: got %b want %b", act, 7'b0);
        end
        model_reset(); refresh_src();
        @(posedge Clk); @(posedge Clk); #1;
        nReset = 1;
        w3 = 8'($urandom);
        src_q = '{w3}; refresh_src();
        got = '0; np = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            n_chk++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL arst_post cyc %0d: got %b want %b", c, act, exp_vec());
            end
            if (PixelValid && np < 8 / b) begin got = (got << b) | 8'(Pixel); np++; end
            tick();
        end
        n_chk++;
        if (got !== w3 || np != 8 / b) begin
            n_fail++; $display("FAIL arst_word: got %h n=%0d want %h", got, np, w3);
        end
    endtask

    task automatic test_random();
        flush();
        for (int c = 0; c < 600; c++) begin
            pe   = ($urandom_range(0, 2) != 0);
            ls   = ($urandom_range(0, 39) == 0);
            mode = 2'($urandom);
            if (src_q.size() < 2 && $urandom_range(0, 1) == 1) src_q.push_back(8'($urandom));
            refresh_src();
            if ($urandom_range(0, 3) == 0) fetch.DataValid = 1'b0;
            @(negedge Clk);
            n_chk++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d: got %b want %b", c, act, exp_vec());
            end
            tick();
        end
        ls = 0;
    endtask

    initial begin
        fetch.DataValid = 1'b0;
        fetch.Data      = '0;
        test_reset();
        test_1bpp();
        test_mode_switch();
        test_underrun();
        test_linestart();
        test_throughput();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_serialiser.md
Name: pixel_serialiser

Overview:
Parametrised, double-buffered successor to the single-byte pixel shifter in the VDG datapath. Accepts display-fetch words over a valid/ready handshake into a holding register. Shifts pixels out MSB-first at 1, 2 or 4 bits per pixel under a pixel-clock enable. Flags underrun when fetch cannot keep up, and sits between the video fetch sequencer and the palette/DAC stage.

Parameters:
DATA_W, 8, fetch word width; multiple of MAX_BPP, at least 8.
MAX_BPP, 4, widest pixel supported; sets Pixel width; power of two (1, 2 or 4).

Ports:
Clk  in  1  system clock.
nReset  in  1  asynchronous active-low reset.
PixelEn  in  1  one-cycle pixel strobe; shifting happens only when high.
Mode  in  2  00=1bpp, 01=2bpp, 10=4bpp, 11=reserved (treated as 1bpp); modes wider than MAX_BPP are treated as 1bpp.
LineStart  in  1  synchronous flush at the start of each active line.
Data  in  DATA_W  fetch word.
DataValid  in  1  Data is valid.
DataReady  out  1  holding register can accept Data this cycle.
Pixel  out  MAX_BPP  current pixel, right-justified and zero-extended.
PixelValid  out  1  Pixel holds real data rather than underrun fill.
Underrun  out  1  one-cycle pulse when a word was needed and none was held.

Behaviour:
- Reset (async, nReset low): shift register, holding register and counters all 0. HoldFull=0, ShiftFull=0, DataReady=0 while in reset and 1 on the first cycle after. Pixel=0, PixelValid=0, Underrun=0.
- Accept: Data is written to the holding register when DataValid & DataReady at the Clk edge.
- DataReady = !HoldFull | Transfer, combinational. Accept and transfer in the same cycle are legal; the holding register is refilled without a bubble.
- Transfer condition: PixelEn & (ShiftFull==0 | RemainCount==1) & HoldFull.
- On transfer, the holding word moves to the shift register. Mode is sampled into ActiveMode. RemainCount is set to DATA_W/bpp. A Mode change therefore takes effect only on a word boundary.
- Shift: on PixelEn with RemainCount>1, the shift register shifts left by bpp and RemainCount decrements.
- On the final pixel with no held word: ShiftFull clears, and the next PixelEn raises Underrun for 1 cycle.
- Pixel = top bpp bits of the shift register, zero-extended, from a combinational mux on ActiveMode.
- PixelValid = ShiftFull. Pixel is forced to 0 when ShiftFull is 0 (black fill).
- Underrun pulses again on every PixelEn that finds both registers empty. It is never raised before the first word after reset or after LineStart: an Armed flag is set on the first transfer and cleared by reset and LineStart.
- LineStart has priority over everything else. It clears HoldFull, ShiftFull, RemainCount and Armed. DataReady is 0 in that cycle, so coincident Data is not accepted.
- PixelEn low: all state holds, and accepts still occur.
- Output latency: the first pixel of a word appears on Pixel the cycle after the transfer edge.

Optional Feature:
PIXEL_DOUBLE_EN: adds input DoubleWidth.
- When high, each pixel is held for two PixelEn strobes: an internal toggle gates shift/transfer, and Underrun is evaluated on the gated strobe.
- The toggle is cleared by reset, LineStart and transfer.
- Macro undefined: port absent, and every PixelEn advances one pixel.

Decomposition:
- Shared package video_pkg holds the mode encodings (MODE_1BPP, MODE_2BPP, MODE_4BPP) and the function bpp_of(mode).
- One sub-module, pixel_hold_reg, contains the holding register, HoldFull and the DataReady logic.
- The shift/count/underrun logic stays in the top level.

Test Plan:
1. DATA_W=8, Mode=00, Data=8'hA5 then held 8'h3C, PixelEn every cycle -> Pixel LSB sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; PixelValid high throughout; no Underrun.
2. Mode=01, Data=8'hE4 -> Pixel 3,2,1,0. Then Mode=10 set mid-word, next Data=8'h7F -> old word finishes at 2bpp, then Pixel 7, F.
3. Single word 8'hFF at 2bpp, no further Data -> 4 pixels of 3, then Pixel=0, PixelValid=0, Underrun pulses on each following PixelEn.
4. LineStart asserted with HoldFull=1 and DataValid=1 -> next cycle PixelValid=0, DataReady=1, word discarded, no Underrun until after the next transfer.
5. PixelEn every 4th cycle, DataValid always high -> DataReady low while full; no word is lost or duplicated across 64 words of a counting pattern.
6. nReset pulsed mid-word -> all outputs 0 immediately (asynchronously); the first word after release is output intact.
